wb_gpio: RTL

- Wishbone classic responder that provides the GPIO peripheral for the crush SoC, sitting on the shared CPU bus next to memory.
- Holds output and direction registers, synchronises the input pins, latches rising and falling edges, and raises one level interrupt.
- Drives zeros on all response outputs when not addressed, so it can share the wired-OR ack/err/rty/data bus.

---
 rtl/wb_gpio.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_gpio.sv
// Wishbone classic GPIO responder: output/direction registers, synchronised
// inputs with latched rising/falling edges, and one level interrupt.
// Response outputs are all zero unless this block is addressed, so they can
// be OR-combined with other responders on the shared bus.
module wb_gpio #(
    parameter logic [31:0] BASE_ADDRESS = 32'h2000_0000,
    parameter logic [31:0] SIZE         = 32'h0000_0020,
    parameter int          WIDTH        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stb_i,
    input  logic             cyc_i,
    input  logic [31:0]      adr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    input  logic             we_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             rty_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    // One past the last decoded byte; 33 bits so a window at the top of the
    // address space does not wrap.
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDRESS} + {1'b0, SIZE};
    // First offset past the implemented register file.
    localparam logic [31:0] OFF_LIMIT = 32'h0000_0018;

    // Register indices (offset / 4).
    localparam logic [2:0] IDX_OUT   = 3'd0;
    localparam logic [2:0] IDX_OE    = 3'd1;
    localparam logic [2:0] IDX_IN    = 3'd2;
    localparam logic [2:0] IDX_RISE  = 3'd3;
    localparam logic [2:0] IDX_FALL  = 3'd4;
    localparam logic [2:0] IDX_IRQEN = 3'd5;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // State
    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] oe_q,    oe_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic [WIDTH-1:0] irqen_q, irqen_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] sync3_q, sync3_d;
    logic [31:0]      dat_q,   dat_d;
    logic             ack_q,   ack_d;
    logic             err_q,   err_d;

    // Decode and transfer qualification
    logic             in_win_s;
    logic [31:0]      offset_s;
    logic [2:0]       reg_idx_s;
    logic             selected_s;
    logic             accept_s;
    logic             bad_s;
    logic             wr_s;
    logic             rd_s;
    logic [31:0]      wmask_full_s;
    logic [WIDTH-1:0] wmask_s;
    logic [WIDTH-1:0] wdat_s;
    logic [WIDTH-1:0] clr_rise_s;
    logic [WIDTH-1:0] clr_fall_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign in_win_s   = ({1'b0, adr_i} >= {1'b0, BASE_ADDRESS}) && ({1'b0, adr_i} < END_ADDR);
    assign offset_s   = adr_i - BASE_ADDRESS;
    assign reg_idx_s  = offset_s[4:2];
    assign selected_s = cyc_i & stb_i & in_win_s;
    // While a response pulse is out, the same held request must not be taken
    // again; this gives one pulse per transfer and a 2-cycle minimum spacing.
    assign accept_s   = selected_s & ~ack_q & ~err_q;
    assign bad_s      = (adr_i[1:0] != 2'b00) || (offset_s >= OFF_LIMIT);
    assign wr_s       = accept_s & ~bad_s & we_i;
    assign rd_s       = accept_s & ~bad_s & ~we_i;

    assign wmask_full_s = lane_mask(sel_i);
    assign wmask_s      = wmask_full_s[WIDTH-1:0];
    assign wdat_s       = dat_i[WIDTH-1:0];
    // Bits above WIDTH are intentionally ignored.
    assign unused_s     = ^{dat_i, wmask_full_s};

    // Register write decode: lane-masked updates and W1C clear masks.
    always_comb begin
        out_d      = out_q;
        oe_d       = oe_q;
        irqen_d    = irqen_q;
        clr_rise_s = {WIDTH{1'b0}};
        clr_fall_s = {WIDTH{1'b0}};
        if (wr_s) begin
            case (reg_idx_s)
                IDX_OUT:   out_d      = (out_q & ~wmask_s) | (wdat_s & wmask_s);
                IDX_OE:    oe_d       = (oe_q & ~wmask_s) | (wdat_s & wmask_s);
                IDX_RISE:  clr_rise_s = wdat_s & wmask_s;
                IDX_FALL:  clr_fall_s = wdat_s & wmask_s;
                IDX_IRQEN: irqen_d    = (irqen_q & ~wmask_s) | (wdat_s & wmask_s);
                default:   out_d      = out_q;   // IN is read-only
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // Input synchroniser, history stage and edge latches; a new edge beats a
    // simultaneous W1C so no event is lost.
    always_comb begin
        sync1_d = gpio_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise_d  = (rise_q & ~clr_rise_s) | (sync2_q & ~sync3_q);
        fall_d  = (fall_q & ~clr_fall_s) | (~sync2_q & sync3_q);
    end

    // Read mux and bus response; data is zero except in a read's ack cycle.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_idx_s)
            IDX_OUT:   rdata_s[WIDTH-1:0] = out_q;
            IDX_OE:    rdata_s[WIDTH-1:0] = oe_q;
            IDX_IN:    rdata_s[WIDTH-1:0] = sync2_q;
            IDX_RISE:  rdata_s[WIDTH-1:0] = rise_q;
            IDX_FALL:  rdata_s[WIDTH-1:0] = fall_q;
            IDX_IRQEN: rdata_s[WIDTH-1:0] = irqen_q;
            default:   rdata_s = 32'h0000_0000;
        endcase
        if (rd_s) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
        ack_d = accept_s & ~bad_s;
        err_d = accept_s & bad_s;
    end

    // All state flops; reset clears everything and drops any pending response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q   <= {WIDTH{1'b0}};
            oe_q    <= {WIDTH{1'b0}};
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            irqen_q <= {WIDTH{1'b0}};
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
            sync3_q <= {WIDTH{1'b0}};
            dat_q   <= 32'h0000_0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irqen_q <= irqen_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign dat_o   = dat_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rty_o   = 1'b0;
    assign gpio_o  = out_q;
    assign gpio_oe = oe_q;
    assign irq_o   = |((rise_q | fall_q) & irqen_q);

endmodule
